// File: rtl/spi_sched_pkg.sv
// Shared types for the SPI transaction scheduler: FSM states, latched transfer
// config and word-length masking of received data.
package spi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [1:0]  mode;
    logic [1:0]  speed;
    logic [1:0]  word_len;
    logic [7:0]  ifg;
    logic [7:0]  cs_sck;
    logic [7:0]  sck_cs;
    logic [31:0] mosi;
  } spi_cfg_t;

  localparam logic [1:0] WL_8  = 2'b00;
  localparam logic [1:0] WL_16 = 2'b01;
  localparam logic [1:0] WL_24 = 2'b10;
  localparam logic [1:0] WL_32 = 2'b11;

  // Bits beyond the configured word length are not driven by the shifter.
  function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [1:0] len);
    case (len)
      WL_8:    return {24'b0, d[7:0]};
      WL_16:   return {16'b0, d[15:0]};
      WL_24:   return {8'b0, d[23:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N_REQ.
module spi_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Scan from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[ID_W'((int'(ptr) + i) % N_REQ)]) begin
        any = 1'b1;
        idx = ID_W'((int'(ptr) + i) % N_REQ);
      end
    end
    gnt = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one SPI master between N_REQ requesters: RR grant, latch config,
// pulse start, track busy, return masked MISO word with ID and timeout flag.
module spi_txn_scheduler
  import spi_sched_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int ID_W          = $clog2(N_REQ),
  parameter int START_TIMEOUT = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [2*N_REQ-1:0]  req_spi_mode,
  input  logic [2*N_REQ-1:0]  req_sck_speed,
  input  logic [2*N_REQ-1:0]  req_word_len,
  input  logic [8*N_REQ-1:0]  req_ifg,
  input  logic [8*N_REQ-1:0]  req_cs_sck,
  input  logic [8*N_REQ-1:0]  req_sck_cs,
  input  logic [32*N_REQ-1:0] req_mosi_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ID_W-1:0]     resp_id,
  output logic [31:0]         resp_data,
  output logic                resp_err,
  output logic                start_out,
  output logic [1:0]          spi_mode_out,
  output logic [1:0]          sck_speed_out,
  output logic [1:0]          word_len_out,
  output logic [7:0]          ifg_out,
  output logic [7:0]          cs_sck_out,
  output logic [7:0]          sck_cs_out,
  output logic [31:0]         mosi_data_out,
  input  logic                busy_in,
  input  logic [31:0]         miso_data_in
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  sched_state_e     state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, gnt_idx, gnt_id_q;
  logic [N_REQ-1:0] gnt_oh;
  logic             gnt_any;
  logic [CNT_W-1:0] to_cnt_q;
  spi_cfg_t         req_cfg [N_REQ];
  spi_cfg_t         cfg_q;
  logic             do_grant, do_done, do_timeout;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_cfg[gi] = '{mode:     req_spi_mode[2*gi +: 2],
                           speed:    req_sck_speed[2*gi +: 2],
                           word_len: req_word_len[2*gi +: 2],
                           ifg:      req_ifg[8*gi +: 8],
                           cs_sck:   req_cs_sck[8*gi +: 8],
                           sck_cs:   req_sck_cs[8*gi +: 8],
                           mosi:     req_mosi_data[32*gi +: 32]};
  end

  spi_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt_oh),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // WAIT_BUSY is entered only after the start pulse, so a busy left high from
  // the previous transfer during LAUNCH is never mistaken for acceptance.
  always_comb begin
    state_d    = state_q;
    do_grant   = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    case (state_q)
      IDLE: if (gnt_any) begin
        do_grant = 1'b1;
        state_d  = LAUNCH;
      end
      LAUNCH: state_d = WAIT_BUSY;
      WAIT_BUSY:
        if (busy_in) state_d = WAIT_DONE;
        else if (to_cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          state_d    = RESP;
        end
      WAIT_DONE: if (!busy_in) begin
        do_done = 1'b1;
        state_d = RESP;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (do_grant && RST) ? gnt_oh : '0;
  assign start_out  = (state_q == LAUNCH);
  assign resp_valid = (state_q == RESP);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rr_ptr_q  <= '0;
      gnt_id_q  <= '0;
      cfg_q     <= '0;
      to_cnt_q  <= '0;
      resp_id   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (do_grant) begin
        cfg_q    <= req_cfg[gnt_idx];
        gnt_id_q <= gnt_idx;
        rr_ptr_q <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state_q == LAUNCH)         to_cnt_q <= '0;
      else if (state_q == WAIT_BUSY) to_cnt_q <= to_cnt_q + 1'b1;
      if (do_done) begin
        resp_id   <= gnt_id_q;
        resp_data <= mask_word(miso_data_in, cfg_q.word_len);
        resp_err  <= 1'b0;
      end else if (do_timeout) begin
        resp_id   <= gnt_id_q;
        resp_data <= '0;
        resp_err  <= 1'b1;
      end
    end
  end

  assign spi_mode_out  = cfg_q.mode;
  assign sck_speed_out = cfg_q.speed;
  assign word_len_out  = cfg_q.word_len;
  assign ifg_out       = cfg_q.ifg;
  assign cs_sck_out    = cfg_q.cs_sck;
  assign sck_cs_out    = cfg_q.sck_cs;
  assign mosi_data_out = cfg_q.mosi;

endmodule

// File: doc/spi_txn_scheduler.md
Name: spi_txn_scheduler

Overview:
- Shares the single SPI master datapath (start/config/MOSI in, busy/MISO out) between N_REQ independent requesters.
- Round-robin arbitration picks one request, latches its full transfer configuration, launches it with a one-cycle start pulse and tracks busy until completion.
- Returns the word-length-masked MISO word with the requester ID and an error flag.
- Sits between the AXI-side register banks and the SPI master.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), requester ID width.
- START_TIMEOUT, 16, cycles allowed after start for busy to rise before the transfer is aborted with an error.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  one-hot accept; asserts for exactly one cycle on grant.
- req_spi_mode  in  2*N_REQ  packed per-requester SPI mode.
- req_sck_speed  in  2*N_REQ  packed SCK speed select.
- req_word_len  in  2*N_REQ  packed word length (00=8, 01=16, 10=24, 11=32 bits).
- req_ifg  in  8*N_REQ  packed inter-frame gap.
- req_cs_sck  in  8*N_REQ  packed CS-to-SCK delay.
- req_sck_cs  in  8*N_REQ  packed SCK-to-CS delay.
- req_mosi_data  in  32*N_REQ  packed MOSI words.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  ID of the granted requester.
- resp_data  out  32  masked MISO word.
- resp_err  out  1  start timeout occurred.
- start_out  out  1  one-cycle start pulse to the SPI master.
- spi_mode_out  out  2  latched config to the SPI master.
- sck_speed_out  out  2  latched config to the SPI master.
- word_len_out  out  2  latched config to the SPI master.
- ifg_out  out  8  latched config to the SPI master.
- cs_sck_out  out  8  latched config to the SPI master.
- sck_cs_out  out  8  latched config to the SPI master.
- mosi_data_out  out  32  latched MOSI word to the SPI master.
- busy_in  in  1  SPI master busy.
- miso_data_in  in  32  SPI master received word.

Behaviour:
- Reset (RST low, asynchronous):
  - State IDLE, RR pointer 0.
  - All outputs 0: req_ready, start_out, resp_valid, resp_err, resp_id, resp_data, and all config/MOSI outputs.
  - Reset mid-transfer abandons the transfer; no response is issued.
- IDLE:
  - If any req_valid is set, grant the first set index at or after the RR pointer, wrapping modulo N_REQ.
  - Assert req_ready[g] for that cycle and latch g's fields into the config/MOSI outputs.
  - Pointer becomes g+1 mod N_REQ. Next state LAUNCH.
  - If no req_valid is set, remain in IDLE.
- LAUNCH:
  - start_out=1 for exactly this cycle; timeout counter cleared. Next state WAIT_BUSY.
- WAIT_BUSY:
  - busy_in=1 -> WAIT_DONE.
  - Counter reaches START_TIMEOUT with busy still 0 -> RESP with resp_err=1 and resp_data=0.
- WAIT_DONE:
  - Wait for busy_in=0. In the cycle busy_in is seen low, capture miso_data_in masked to word_len: upper bits beyond 8/16/24/32 forced to 0.
  - Set resp_err=0, resp_id=g. Next state RESP.
- RESP:
  - resp_valid=1 with resp_id, resp_data and resp_err held stable until resp_ready=1.
  - On handshake, resp_valid=0 next cycle and state returns to IDLE.
  - The earliest next grant is the cycle after the handshake, so there is no back-to-back overlap.
- Config/MOSI outputs hold the latched values from grant until the next grant; they never change while busy_in=1.
- Latency: request accepted -> start_out is 1 cycle; busy fall -> resp_valid is 1 cycle.
- req_valid deasserted after acceptance has no effect. Requesters must hold req_valid and their fields stable until req_ready.
- busy_in already high in LAUNCH (stale from a previous transfer) is not treated as a start. WAIT_BUSY samples busy only from the cycle after start_out.

Decomposition:
- Shared package spi_sched_pkg:
  - state enum sched_state_e {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP}.
  - typedef spi_cfg_t struct: mode, speed, word_len, ifg, cs_sck, sck_cs, mosi.
  - Word-length encoding constants and mask function.
- One sub-module: spi_rr_arbiter (N_REQ request vector plus pointer -> one-hot grant and index), reusable elsewhere.

Test Plan:
- Single request: requester 2, mode 01, len 01, mosi 0xA5A5_1234; master returns miso 0xDEAD_BEEF -> start_out 1 cycle after req_ready[2]; resp_id=2, resp_data=0x0000_BEEF, resp_err=0.
- Round-robin: all 4 req_valid held continuously -> grant order 0,1,2,3,0; each response carries the matching ID.
- Timeout: busy_in held 0 after start -> resp_valid with resp_err=1, resp_data=0 exactly START_TIMEOUT cycles after WAIT_BUSY entry; then the next grant proceeds normally.
- Backpressure: resp_ready=0 for 10 cycles -> resp_valid, resp_id and resp_data stable; no new req_ready while pending.
- Config stability: requester changes req_ifg from 0x10 to 0x20 after grant -> ifg_out stays 0x10 through busy.
- Async reset: RST low during WAIT_DONE -> all outputs 0 immediately; after release, requester 0 is granted first with no stale response.
